serial_addsub_core: RTL

SERIAL_ADDSUB_CORE -- requirements
Module: serial_addsub_core

---
 rtl/serial_pkg.sv | 5 +
 rtl/serial_fa.sv | 11 +
 rtl/serial_addsub_core.sv | 70 +++++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM state type and default operand width for the serial add/sub core.
package serial_pkg;
  localparam int BIT_WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
endpackage

// File: rtl/serial_fa.sv
// serial_fa: combinational 1-bit full adder.
module serial_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_addsub_core.sv
// serial_addsub_core: bit-serial A+B / A-B sequencer driving external operand and result shift registers.
module serial_addsub_core
  import serial_pkg::*;
#(
  parameter int BIT_WIDTH = BIT_WIDTH_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic sub,
  input  logic a_bit,
  input  logic b_bit,
  output logic sr_enable,
  output logic sr_load,
  output logic sum_bit,
  output logic sum_valid,
  output logic busy,
  output logic done,
  output logic carry_out,
  output logic overflow
);
  localparam int CW = $clog2(BIT_WIDTH) + 1;
  state_t state;
  logic mode, carry, b_eff, s, cout;
  logic [CW-1:0] cnt;
  // subtraction is A + ~B + 1: invert B per bit and seed the carry with mode
  assign b_eff = b_bit ^ mode;
  serial_fa u_fa (.a(a_bit), .b(b_eff), .cin(carry), .s(s), .cout(cout));
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mode <= 1'b0;
      carry <= 1'b0;
      cnt <= '0;
      carry_out <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          mode <= sub;
          carry_out <= 1'b0;
          overflow <= 1'b0;
        end
        LOAD: begin
          carry <= mode;
          cnt <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          carry <= cout;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(BIT_WIDTH - 1)) begin
            carry_out <= cout;
            overflow <= carry ^ cout;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign sr_enable = (state == LOAD) || (state == SHIFT);
  assign sr_load = state == LOAD;
  assign sum_valid = state == SHIFT;
  assign sum_bit = (state == SHIFT) & s;
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule
